alu_cmd_sequencer: RTL and testbench

// - Command controller for the dual-memory + ALU datapath (operand memories A/B, registered opcode, registered result).
// - Accepts one command per valid/ready handshake: write operand A, write operand B, or execute.
// - Sequences memory strobes and opcode for each command, captures result/carry and returns one response per command.

---
 rtl/alu_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command controller for the dual-memory + ALU datapath: one command per handshake, one response per command.
// Optional statistics outputs (stat_ops, stat_errs) are built only when ALU_SEQ_STATS_EN is defined.
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int DP_LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_kind,
  input  logic [ADDRESS_WIDTH-1:0] cmd_opcode,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr_a,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr_b,
  input  logic [DATA_WIDTH-1:0]    cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_carry,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     cs0,
  output logic                     cs1,
  output logic                     mem_en0,
  output logic                     mem_en1,
  output logic [ADDRESS_WIDTH-1:0] addr0,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0]    wdata0,
  output logic [DATA_WIDTH-1:0]    wdata1,
  output logic [ADDRESS_WIDTH-1:0] opcode_out,
  input  logic [DATA_WIDTH-1:0]    dp_result,
  input  logic                     dp_carry
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]              stat_ops,
  output logic [7:0]               stat_errs
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [1:0] K_EXEC    = 2'b00;
  localparam logic [1:0] K_WRITE_A = 2'b01;
  localparam logic [1:0] K_WRITE_B = 2'b10;

  localparam int CW = $clog2(DP_LATENCY + 1);

  logic [2:0]               state;
  logic [1:0]               kind_q;
  logic [ADDRESS_WIDTH-1:0] addr_a_q;
  logic [ADDRESS_WIDTH-1:0] addr_b_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [ADDRESS_WIDTH-1:0] opcode_q;
  logic [CW-1:0]            wait_cnt;
  logic                     rsp_fire;

  assign rsp_fire = (state == S_RESP) && rsp_ready;

  // opcode_q only reloads on an accepted EXEC, so opcode_out holds between operations.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      kind_q    <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      wdata_q   <= '0;
      opcode_q  <= '0;
      wait_cnt  <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            kind_q   <= cmd_kind;
            addr_a_q <= cmd_addr_a;
            addr_b_q <= cmd_addr_b;
            wdata_q  <= cmd_wdata;
            case (cmd_kind)
              K_EXEC: begin
                opcode_q <= cmd_opcode;
                state    <= S_ISSUE;
              end
              K_WRITE_A, K_WRITE_B: state <= S_WRITE;
              default: begin
                rsp_data  <= '0;
                rsp_carry <= 1'b0;
                rsp_err   <= 1'b1;
                state     <= S_RESP;
              end
            endcase
          end
        end
        S_WRITE: begin
          rsp_data  <= wdata_q;
          rsp_carry <= 1'b0;
          rsp_err   <= 1'b0;
          state     <= S_RESP;
        end
        S_ISSUE: begin
          wait_cnt <= CW'(DP_LATENCY);
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt == CW'(1)) begin
            rsp_data  <= dp_result;
            rsp_carry <= dp_carry;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    cs0     = (state == S_ISSUE) || ((state == S_WRITE) && (kind_q == K_WRITE_A));
    cs1     = (state == S_ISSUE) || ((state == S_WRITE) && (kind_q == K_WRITE_B));
    mem_en0 = (state == S_WRITE) && (kind_q == K_WRITE_A);
    mem_en1 = (state == S_WRITE) && (kind_q == K_WRITE_B);
  end

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign rsp_valid  = (state == S_RESP);
  assign addr0      = addr_a_q;
  assign addr1      = addr_b_q;
  assign wdata0     = wdata_q;
  assign wdata1     = wdata_q;
  assign opcode_out = opcode_q;

`ifdef ALU_SEQ_STATS_EN
  // Saturating counters of completed responses, split by error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops  <= '0;
      stat_errs <= '0;
    end else if (rsp_fire) begin
      if (rsp_err) begin
        if (stat_errs != 8'hFF) stat_errs <= stat_errs + 8'd1;
      end else begin
        if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: directed scenarios plus random commands against a memory/ALU reference model.
// Statistics checks are compiled in only when ALU_SEQ_STATS_EN is defined.
module tb_alu_cmd_sequencer;

  logic       clk;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [3:0] cmd_opcode;
  logic [3:0] cmd_addr_a;
  logic [3:0] cmd_addr_b;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
  logic       busy;
  logic       cs0;
  logic       cs1;
  logic       mem_en0;
  logic       mem_en1;
  logic [3:0] addr0;
  logic [3:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [3:0] opcode_out;
  logic [7:0] dp_result;
  logic       dp_carry;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_errs;
`endif

  int total;
  int bad;
  int exp_ops;
  int exp_errs;
  logic [3:0] last_op;
  logic [7:0] shadow_a [16];
  logic [7:0] shadow_b [16];
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  logic [7:0] rd_a;
  logic [7:0] rd_b;

  alu_cmd_sequencer #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .DP_LATENCY(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
    .cmd_opcode(cmd_opcode), .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .busy(busy),
    .cs0(cs0), .cs1(cs1), .mem_en0(mem_en0), .mem_en1(mem_en1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .opcode_out(opcode_out), .dp_result(dp_result), .dp_carry(dp_carry)
`ifdef ALU_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_errs(stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour of the surrounding datapath: {carry, result}.
  function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return {1'b0, a} + {1'b0, b};
      4'd1:    return {1'b0, a} - {1'b0, b};
      4'd2:    return {1'b0, a & b};
      4'd3:    return {1'b0, a | b};
      4'd4:    return {1'b0, a ^ b};
      default: return {1'b0, a};
    endcase
  endfunction

  // Datapath model: registered memory reads one edge after the read strobes, registered ALU one edge later.
  always @(posedge clk) begin
    if (cs0 && mem_en0) mem_a[addr0] <= wdata0;
    if (cs1 && mem_en1) mem_b[addr1] <= wdata1;
    if (cs0 && !mem_en0) rd_a <= mem_a[addr0];
    if (cs1 && !mem_en1) rd_b <= mem_b[addr1];
    {dp_carry, dp_result} <= alu_ref(opcode_out, rd_a, rd_b);
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_cmd_ready"}, cmd_ready, 1);
    check_output({tag, "_rsp_valid"}, rsp_valid, 0);
    check_output({tag, "_rsp_data"}, rsp_data, 0);
    check_output({tag, "_rsp_carry"}, rsp_carry, 0);
    check_output({tag, "_rsp_err"}, rsp_err, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_strobes"}, {cs0, cs1, mem_en0, mem_en1}, 0);
    check_output({tag, "_addr"}, {addr0, addr1}, 0);
    check_output({tag, "_wdata"}, {wdata0, wdata1}, 0);
    check_output({tag, "_opcode_out"}, opcode_out, 0);
  endtask

  task automatic scramble_cmd();
    cmd_kind   = 2'($urandom_range(0, 3));
    cmd_opcode = 4'($urandom_range(0, 15));
    cmd_addr_a = 4'($urandom_range(0, 15));
    cmd_addr_b = 4'($urandom_range(0, 15));
    cmd_wdata  = 8'($urandom_range(0, 255));
  endtask

  // Issue one command, follow it to its response, hold the response for 'hold' cycles, then consume it.
  task automatic apply_stimulus(input string tag, input logic [1:0] kind, input logic [3:0] op,
                                input logic [3:0] a, input logic [3:0] b, input logic [7:0] d,
                                input int hold);
    logic [8:0] expected;
    logic [7:0] held_data;
    int exp_lat;
    int lat;
    int n_cs0, n_cs1, n_en0, n_en1;
    int e_cs0, e_cs1, e_en0, e_en1;
    case (kind)
      2'b00: begin expected = alu_ref(op, shadow_a[a], shadow_b[b]); exp_lat = 3;
                   e_cs0 = 1; e_cs1 = 1; e_en0 = 0; e_en1 = 0; end
      2'b01: begin expected = {1'b0, d}; exp_lat = 1; e_cs0 = 1; e_cs1 = 0; e_en0 = 1; e_en1 = 0; end
      2'b10: begin expected = {1'b0, d}; exp_lat = 1; e_cs0 = 0; e_cs1 = 1; e_en0 = 0; e_en1 = 1; end
      default: begin expected = 9'd0; exp_lat = 0; e_cs0 = 0; e_cs1 = 0; e_en0 = 0; e_en1 = 0; end
    endcase
    if (kind == 2'b00) last_op = op;

    @(negedge clk);
    check_output({tag, "_ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_kind = kind; cmd_opcode = op;
    cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = d;
    @(posedge clk);
    lat = 0; n_cs0 = 0; n_cs1 = 0; n_en0 = 0; n_en1 = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    scramble_cmd();
    while (!rsp_valid && lat < 20) begin
      n_cs0 += int'(cs0); n_cs1 += int'(cs1); n_en0 += int'(mem_en0); n_en1 += int'(mem_en1);
      lat++;
      @(negedge clk);
    end
    check_output({tag, "_latency"}, lat, exp_lat);
    check_output({tag, "_rsp_data"}, rsp_data, expected[7:0]);
    check_output({tag, "_rsp_carry"}, rsp_carry, expected[8]);
    check_output({tag, "_rsp_err"}, rsp_err, kind == 2'b11);
    check_output({tag, "_cs_pulses"}, {n_cs0[7:0], n_cs1[7:0]}, {e_cs0[7:0], e_cs1[7:0]});
    check_output({tag, "_en_pulses"}, {n_en0[7:0], n_en1[7:0]}, {e_en0[7:0], e_en1[7:0]});
    check_output({tag, "_opcode_out"}, opcode_out, last_op);

    held_data = rsp_data;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1;
      scramble_cmd();
      @(negedge clk);
      check_output({tag, "_hold_valid"}, rsp_valid, 1);
      check_output({tag, "_hold_data"}, {rsp_data, rsp_carry, rsp_err},
                   {held_data, expected[8], kind == 2'b11});
      check_output({tag, "_hold_quiet"}, {cmd_ready, cs0, cs1, mem_en0, mem_en1}, 0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_output({tag, "_after_rsp"}, {rsp_valid, busy, cmd_ready}, 3'b001);

    if (kind == 2'b01) shadow_a[a] = d;
    if (kind == 2'b10) shadow_b[b] = d;
    if (kind == 2'b11) exp_errs++;
    else exp_ops++;
  endtask

  initial begin
    int r;
    logic [1:0] k;
    total = 0; bad = 0; exp_ops = 0; exp_errs = 0; last_op = 4'd0;
    for (int i = 0; i < 16; i++) begin
      shadow_a[i] = 8'd0; shadow_b[i] = 8'd0; mem_a[i] = 8'd0; mem_b[i] = 8'd0;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_kind = 2'd0; cmd_opcode = 4'd0; cmd_addr_a = 4'd0; cmd_addr_b = 4'd0; cmd_wdata = 8'd0;

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    apply_stimulus("wa_3", 2'b01, 4'd0, 4'd3, 4'd0, 8'h25, 0);
    apply_stimulus("wb_3", 2'b10, 4'd0, 4'd0, 4'd3, 8'h1A, 0);
    apply_stimulus("add_3f", 2'b00, 4'd0, 4'd3, 4'd3, 8'h00, 0);
    check_output("add_3f_const", {rsp_carry, rsp_data}, 9'h000);

    apply_stimulus("wa_1", 2'b01, 4'd0, 4'd1, 4'd0, 8'hF0, 0);
    apply_stimulus("wb_2", 2'b10, 4'd0, 4'd0, 4'd2, 8'h20, 0);
    apply_stimulus("add_carry", 2'b00, 4'd0, 4'd1, 4'd2, 8'h00, 5);
    apply_stimulus("reserved", 2'b11, 4'd7, 4'd1, 4'd2, 8'hAA, 2);

    // Reset while the EXEC is waiting on the datapath.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_kind = 2'b00; cmd_opcode = 4'd4; cmd_addr_a = 4'd1; cmd_addr_b = 4'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_output("wait_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    exp_ops = 0; exp_errs = 0; last_op = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("post_reset_quiet", {rsp_valid, busy}, 0);
    end
    apply_stimulus("exec_after_reset", 2'b00, 4'd1, 4'd1, 4'd3, 8'h00, 1);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      k = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r < 9) ? 2'b00 : 2'b11;
      apply_stimulus("random", k, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                     4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end

`ifdef ALU_SEQ_STATS_EN
    check_output("stat_ops", stat_ops, exp_ops);
    check_output("stat_errs", stat_errs, exp_errs);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
